// File: rtl/i_fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package i_fetch_pkg;

  localparam logic [31:0] NOP_INSTR         = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
  localparam logic [31:0] PC_STEP           = 32'd4;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/i_fetch_instr_mem.sv
// Word-addressed instruction memory: synchronous write from the debug loader,
// asynchronous read so the fetch word is available in the same cycle as the PC.
module instr_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  i_clock,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge i_clock) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/i_fetch.sv
// Instruction fetch stage: PC, IF/ID register pair and the RUN/HALTED machine.
// A fetched HALT word freezes the PC; only reset brings the stage back to RUN.
module i_fetch
  import i_fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 64,
  parameter int                    ADDR_WIDTH = 6,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD  = DATA_WIDTH'(HALT_WORD_DEFAULT)
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_stall,
  input  logic                  i_pcsrc,
  input  logic [DATA_WIDTH-1:0] i_pcbranch,
  input  logic                  i_load_we,
  input  logic [ADDR_WIDTH-1:0] i_load_addr,
  input  logic [DATA_WIDTH-1:0] i_load_data,
  output logic [DATA_WIDTH-1:0] o_instruccion,
  output logic [DATA_WIDTH-1:0] o_currentpc,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic                  o_halt
);

  localparam logic [DATA_WIDTH-1:0] NOP  = DATA_WIDTH'(NOP_INSTR);
  localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(PC_STEP);

  fetch_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] cpc_q, cpc_d;
  logic [DATA_WIDTH-1:0] fetch_word;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic                  adv;
  logic                  fetch_is_halt;

  instr_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_instr_mem (
    .i_clock (i_clock),
    .i_we    (i_load_we),
    .i_waddr (i_load_addr),
    .i_wdata (i_load_data),
    .i_raddr (pc_q[ADDR_WIDTH+1:2]),
    .o_rdata (fetch_word)
  );

  // A load cycle freezes fetch so the read-during-write value is never latched.
  assign adv           = i_enable & ~i_load_we & ~i_reset;
  assign pc_plus4      = pc_q + STEP;
  assign fetch_is_halt = (fetch_word == HALT_WORD);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= RUN;
      pc_q    <= '0;
      instr_q <= NOP;
      cpc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cpc_q   <= cpc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (adv && state_q == RUN && !i_pcsrc && !i_stall && fetch_is_halt) begin
      state_d = HALTED;
    end
  end

  // Redirect beats stall and squashes a HALT word sitting in the shadow.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    cpc_d   = cpc_q;
    if (adv) begin
      if (state_q == HALTED) begin
        instr_d = NOP;
        cpc_d   = '0;
      end else if (i_pcsrc) begin
        pc_d    = i_pcbranch;
        instr_d = NOP;
        cpc_d   = '0;
      end else if (!i_stall) begin
        instr_d = fetch_is_halt ? HALT_WORD : fetch_word;
        cpc_d   = pc_plus4;
        pc_d    = fetch_is_halt ? pc_q : pc_plus4;
      end
    end
  end

  always_comb begin
    o_halt = (state_q == HALTED);
  end

  assign o_instruccion = instr_q;
  assign o_currentpc   = cpc_q;
  assign o_pc          = pc_q;

endmodule

// File: tb/tb_i_fetch.sv
// Scenario bench for i_fetch: each task walks a table of per-cycle stimulus,
// pushes the expected IF/ID state into a scoreboard and checks it after the edge.
module tb_i_fetch;

  logic        clk = 1'b0;
  logic        i_reset = 1'b0, i_enable = 1'b0, i_stall = 1'b0, i_pcsrc = 1'b0;
  logic [31:0] i_pcbranch = '0;
  logic        i_load_we = 1'b0;
  logic [5:0]  i_load_addr = '0;
  logic [31:0] i_load_data = '0;
  logic [31:0] o_instruccion, o_currentpc, o_pc;
  logic        o_halt;

  int n_cmp = 0;
  int n_err = 0;

  // ctl = {reset, enable, stall, pcsrc, load_we}
  typedef struct {
    logic [4:0]  ctl;
    logic [31:0] br;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [31:0] instr;
    logic [31:0] cpc;
    logic [31:0] pc;
    logic        halt;
  } row_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] cpc;
    logic [31:0] pc;
    logic        halt;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  i_fetch dut (
    .i_clock       (clk),
    .i_reset       (i_reset),
    .i_enable      (i_enable),
    .i_stall       (i_stall),
    .i_pcsrc       (i_pcsrc),
    .i_pcbranch    (i_pcbranch),
    .i_load_we     (i_load_we),
    .i_load_addr   (i_load_addr),
    .i_load_data   (i_load_data),
    .o_instruccion (o_instruccion),
    .o_currentpc   (o_currentpc),
    .o_pc          (o_pc),
    .o_halt        (o_halt)
  );

  task automatic drive(input row_t r);
    {i_reset, i_enable, i_stall, i_pcsrc, i_load_we} = r.ctl;
    i_pcbranch  = r.br;
    i_load_addr = r.addr;
    i_load_data = r.data;
    exp_q.push_back('{r.instr, r.cpc, r.pc, r.halt});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    row_t rows [7] = '{
      '{5'b10000, 32'h0, 6'd0,  32'h0,        32'h0, 32'h0, 32'h0, 1'b0},
      '{5'b00001, 32'h0, 6'd0,  32'h20010005, 32'h0, 32'h0, 32'h0, 1'b0},
      '{5'b00001, 32'h0, 6'd1,  32'h20020007, 32'h0, 32'h0, 32'h0, 1'b0},
      '{5'b00001, 32'h0, 6'd2,  32'h00221820, 32'h0, 32'h0, 32'h0, 1'b0},
      '{5'b00001, 32'h0, 6'd3,  32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 1'b0},
      '{5'b00001, 32'h0, 6'd63, 32'h12345678, 32'h0, 32'h0, 32'h0, 1'b0},
      '{5'b00000, 32'h0, 6'd0,  32'h0,        32'h0, 32'h0, 32'h0, 1'b0}
    };
    exp_t e;
    foreach (rows[i]) begin
      drive(rows[i]);
      e = exp_q.pop_front();
      n_cmp++;
      if ({o_instruccion, o_currentpc, o_pc, o_halt} !== {e.instr, e.cpc, e.pc, e.halt}) begin
        n_err++;
        $display("FAIL reset[%0d]: got instr=%h cpc=%h pc=%h halt=%b, want instr=%h cpc=%h pc=%h halt=%b",
                 i, o_instruccion, o_currentpc, o_pc, o_halt, e.instr, e.cpc, e.pc, e.halt);
      end else
        $display("ok   reset[%0d]: instr=%h cpc=%h pc=%h halt=%b", i, o_instruccion, o_currentpc, o_pc, o_halt);
    end
  endtask

  task automatic test_sequential();
    row_t rows [6] = '{
      '{5'b01000, 32'h0, 6'd0, 32'h0, 32'h20010005, 32'd4,  32'd4,  1'b0},
      '{5'b01000, 32'h0, 6'd0, 32'h0, 32'h20020007, 32'd8,  32'd8,  1'b0},
      '{5'b01000, 32'h0, 6'd0, 32'h0, 32'h00221820, 32'd12, 32'd12, 1'b0},
      '{5'b01000, 32'h0, 6'd0, 32'h0, 32'hFFFFFFFF, 32'd16, 32'd12, 1'b1},
      '{5'b01000, 32'h0, 6'd0, 32'h0, 32'h0,        32'd0,  32'd12, 1'b1},
      '{5'b01110, 32'h0, 6'd0, 32'h0, 32'h0,        32'd0,  32'd12, 1'b1}
    };
    exp_t e;
    foreach (rows[i]) begin
      drive(rows[i]);
      e = exp_q.pop_front();
      n_cmp++;
      if ({o_instruccion, o_currentpc, o_pc, o_halt} !== {e.instr, e.cpc, e.pc, e.halt}) begin
        n_err++;
        $display("FAIL sequential[%0d]: got instr=%h cpc=%h pc=%h halt=%b, want instr=%h cpc=%h pc=%h halt=%b",
                 i, o_instruccion, o_currentpc, o_pc, o_halt, e.instr, e.cpc, e.pc, e.halt);
      end else
        $display("ok   sequential[%0d]: instr=%h cpc=%h pc=%h halt=%b", i, o_instruccion, o_currentpc, o_pc, o_halt);
    end
  endtask

  task automatic test_stall();
    row_t rows [6] = '{
      '{5'b11000, 32'h0, 6'd0, 32'h0, 32'h0,        32'd0,  32'd0,  1'b0},
      '{5'b01000, 32'h0, 6'd0, 32'h0, 32'h20010005, 32'd4,  32'd4,  1'b0},
      '{5'b01000, 32'h0, 6'd0, 32'h0, 32'h20020007, 32'd8,  32'd8,  1'b0},
      '{5'b01100, 32'h0, 6'd0, 32'h0, 32'h20020007, 32'd8,  32'd8,  1'b0},
      '{5'b01100, 32'h0, 6'd0, 32'h0, 32'h20020007, 32'd8,  32'd8,  1'b0},
      '{5'b01000, 32'h0, 6'd0, 32'h0, 32'h00221820, 32'd12, 32'd12, 1'b0}
    };
    exp_t e;
    foreach (rows[i]) begin
      drive(rows[i]);
      e = exp_q.pop_front();
      n_cmp++;
      if ({o_instruccion, o_currentpc, o_pc, o_halt} !== {e.instr, e.cpc, e.pc, e.halt}) begin
        n_err++;
        $display("FAIL stall[%0d]: got instr=%h cpc=%h pc=%h halt=%b, want instr=%h cpc=%h pc=%h halt=%b",
                 i, o_instruccion, o_currentpc, o_pc, o_halt, e.instr, e.cpc, e.pc, e.halt);
      end else
        $display("ok   stall[%0d]: instr=%h cpc=%h pc=%h halt=%b", i, o_instruccion, o_currentpc, o_pc, o_halt);
    end
  endtask

  task automatic test_branch();
    row_t rows [2] = '{
      '{5'b01010, 32'h8, 6'd0, 32'h0, 32'h0,        32'd0,  32'd8,  1'b0},
      '{5'b01000, 32'h0, 6'd0, 32'h0, 32'h00221820, 32'd12, 32'd12, 1'b0}
    };
    exp_t e;
    foreach (rows[i]) begin
      drive(rows[i]);
      e = exp_q.pop_front();
      n_cmp++;
      if ({o_instruccion, o_currentpc, o_pc, o_halt} !== {e.instr, e.cpc, e.pc, e.halt}) begin
        n_err++;
        $display("FAIL branch[%0d]: got instr=%h cpc=%h pc=%h halt=%b, want instr=%h cpc=%h pc=%h halt=%b",
                 i, o_instruccion, o_currentpc, o_pc, o_halt, e.instr, e.cpc, e.pc, e.halt);
      end else
        $display("ok   branch[%0d]: instr=%h cpc=%h pc=%h halt=%b", i, o_instruccion, o_currentpc, o_pc, o_halt);
    end
  endtask

  // PC sits on the HALT word at 0xC; redirect plus stall must squash it.
  task automatic test_halt_shadow_wrap();
    row_t rows [5] = '{
      '{5'b01110, 32'h100,      6'd0, 32'h0, 32'h0,        32'h0,   32'h100,      1'b0},
      '{5'b01000, 32'h0,        6'd0, 32'h0, 32'h20010005, 32'h104, 32'h104,      1'b0},
      '{5'b01010, 32'hFFFFFFFC, 6'd0, 32'h0, 32'h0,        32'h0,   32'hFFFFFFFC, 1'b0},
      '{5'b01000, 32'h0,        6'd0, 32'h0, 32'h12345678, 32'h0,   32'h0,        1'b0},
      '{5'b01000, 32'h0,        6'd0, 32'h0, 32'h20010005, 32'h4,   32'h4,        1'b0}
    };
    exp_t e;
    foreach (rows[i]) begin
      drive(rows[i]);
      e = exp_q.pop_front();
      n_cmp++;
      if ({o_instruccion, o_currentpc, o_pc, o_halt} !== {e.instr, e.cpc, e.pc, e.halt}) begin
        n_err++;
        $display("FAIL halt_wrap[%0d]: got instr=%h cpc=%h pc=%h halt=%b, want instr=%h cpc=%h pc=%h halt=%b",
                 i, o_instruccion, o_currentpc, o_pc, o_halt, e.instr, e.cpc, e.pc, e.halt);
      end else
        $display("ok   halt_wrap[%0d]: instr=%h cpc=%h pc=%h halt=%b", i, o_instruccion, o_currentpc, o_pc, o_halt);
    end
  endtask

  task automatic test_enable_load();
    row_t rows [5] = '{
      '{5'b00010, 32'h40, 6'd0, 32'h0,        32'h20010005, 32'd4, 32'd4, 1'b0},
      '{5'b00010, 32'h40, 6'd0, 32'h0,        32'h20010005, 32'd4, 32'd4, 1'b0},
      '{5'b00010, 32'h40, 6'd0, 32'h0,        32'h20010005, 32'd4, 32'd4, 1'b0},
      '{5'b01001, 32'h0,  6'd1, 32'hAABBCCDD, 32'h20010005, 32'd4, 32'd4, 1'b0},
      '{5'b01000, 32'h0,  6'd0, 32'h0,        32'hAABBCCDD, 32'd8, 32'd8, 1'b0}
    };
    exp_t e;
    foreach (rows[i]) begin
      drive(rows[i]);
      e = exp_q.pop_front();
      n_cmp++;
      if ({o_instruccion, o_currentpc, o_pc, o_halt} !== {e.instr, e.cpc, e.pc, e.halt}) begin
        n_err++;
        $display("FAIL enable_load[%0d]: got instr=%h cpc=%h pc=%h halt=%b, want instr=%h cpc=%h pc=%h halt=%b",
                 i, o_instruccion, o_currentpc, o_pc, o_halt, e.instr, e.cpc, e.pc, e.halt);
      end else
        $display("ok   enable_load[%0d]: instr=%h cpc=%h pc=%h halt=%b", i, o_instruccion, o_currentpc, o_pc, o_halt);
    end
  endtask

  // Reset asserted together with a redirect at PC=8; memory must survive.
  task automatic test_reset_midrun();
    row_t rows [3] = '{
      '{5'b11010, 32'h40, 6'd0, 32'h0, 32'h0,        32'd0, 32'd0, 1'b0},
      '{5'b01000, 32'h0,  6'd0, 32'h0, 32'h20010005, 32'd4, 32'd4, 1'b0},
      '{5'b01000, 32'h0,  6'd0, 32'h0, 32'hAABBCCDD, 32'd8, 32'd8, 1'b0}
    };
    exp_t e;
    foreach (rows[i]) begin
      drive(rows[i]);
      e = exp_q.pop_front();
      n_cmp++;
      if ({o_instruccion, o_currentpc, o_pc, o_halt} !== {e.instr, e.cpc, e.pc, e.halt}) begin
        n_err++;
        $display("FAIL reset_midrun[%0d]: got instr=%h cpc=%h pc=%h halt=%b, want instr=%h cpc=%h pc=%h halt=%b",
                 i, o_instruccion, o_currentpc, o_pc, o_halt, e.instr, e.cpc, e.pc, e.halt);
      end else
        $display("ok   reset_midrun[%0d]: instr=%h cpc=%h pc=%h halt=%b", i, o_instruccion, o_currentpc, o_pc, o_halt);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_halt_shadow_wrap();
    test_enable_load();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
